id_ex_pipe_reg: RTL and testbench
=================================

// Module: id_ex_pipe_reg
// PURPOSE
//  ID/EX pipeline register for the 5-stage MIPS core. It sits directly downstream of the ID control
//  decoder and register file, and feeds the EX stage. It latches the decoded control bundle and the
//  operand data, detects load-use hazards and inserts bubbles. It honours flush and hold requests and
//  counts the bubbles it inserts.
// PARAMETERS
//  DATA_W  32  operand / PC datapath width
//  REG_AW  5   register address width
//  CNT_W   16  bubble counter width
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       reset, asynchronous, active-high
//  id_valid     in   1       ID holds a real instruction
//  id_ctrl      in   15      control bundle: [0]beq [1]bne [7:2]aluop [8]memread [9]memwrite
//                            [10]memtoreg [11]regdst [12]regwrite [13]alusrc [14]jump
//  id_pc4       in   DATA_W  PC+4 of the ID instruction
//  id_rs_data   in   DATA_W  rs read data
//  id_rt_data   in   DATA_W  rt read data
//  id_imm       in   DATA_W  sign-extended immediate
//  id_rs/id_rt/id_rd in REG_AW  register specifiers
//  flush        in   1       kill the instruction entering EX (taken branch/jump)
//  hold         in   1       downstream stall: freeze the register
//  ex_valid     out  1       EX holds a real instruction
//  ex_ctrl      out  15      registered control bundle, same bit map
//  ex_pc4/ex_rs_data/ex_rt_data/ex_imm  out DATA_W  registered data
//  ex_rs/ex_rt/ex_rd  out REG_AW  registered specifiers
//  stall_id     out  1       combinational: PC and IF/ID must hold this cycle
//  bubble_cnt   out  CNT_W   bubbles inserted since reset, saturating
// BEHAVIOUR
//  - Reset: every output register is cleared to 0 (ex_valid, ex_ctrl, all data, all specifiers,
//    bubble_cnt). stall_id is driven combinationally from the cleared state, so it reads 0.
//  - hazard = id_valid & ex_valid & ex_ctrl[8] & (ex_rt!=0) & (ex_rt==id_rs | ex_rt==id_rt).
//    The rt compare is always made (conservative).
//  - stall_id = (hazard | hold) & ~flush.
//  - Per rising clk edge, first match wins:
//    1. flush: ex_ctrl<=0, ex_valid<=0, data/specifiers load from id_*. No count.
//    2. hold: all registers keep their values. No count.
//    3. hazard: bubble. ex_ctrl<=0, ex_valid<=0, data/specifiers load from id_*.
//       bubble_cnt<=bubble_cnt+1, saturating at 2^CNT_W-1.
//    4. else: load. ex_ctrl<=id_valid ? id_ctrl : 0, ex_valid<=id_valid, data/specifiers <= id_*.
//  - Latency: one cycle from ID inputs to EX outputs.
//  - A load-use hazard costs exactly one bubble. After the bubble, ex_valid=0, so the hazard
//    deasserts and the stalled instruction loads on the next edge.
//  - With id_valid=0, no hazard can fire. The register loads a bubble (ctrl=0) with no count.
//  - Reset asserted mid-stall clears everything at once. After release the block behaves as a
//    fresh pipeline.
//  - Fully synchronous apart from rst. No multi-cycle paths.
// TESTING
//  1. rst=1 mid-run with ex_ctrl=15'h7FFF -> all outputs 0 at once, before the next clk edge.
//  2. Normal lw: id_ctrl memread|memtoreg|alusrc|regwrite, id_imm=32'h4 -> next cycle ex_ctrl
//     equals it, ex_imm=4, ex_valid=1, stall_id=0.
//  3. Load-use: lw $t0 in EX (ex_rt=8), then add with id_rs=8 -> stall_id=1 for exactly 1 cycle,
//     then ex_ctrl=0 and bubble_cnt=1, then add enters EX.
//  4. Load to $zero: lw with ex_rt=0, then id_rs=0 -> stall_id=0 and no bubble.
//  5. Hazard and flush together -> stall_id=0, ex_valid=0, bubble_cnt unchanged. hold=1 for
//     3 cycles -> all ex_* frozen and stall_id=1.
//  6. CNT_W=2: 5 back-to-back load-use pairs -> bubble_cnt saturates at 3.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register for the 5-stage MIPS core.
// Latches control/operands, inserts load-use bubbles, honours flush/hold.
module id_ex_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [14:0]       id_ctrl,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              flush,
    input  logic              hold,
    output logic              ex_valid,
    output logic [14:0]       ex_ctrl,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic              stall_id,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam int MEMREAD = 8;

    logic hazard;
    logic rt_used;
    logic cnt_full;

    // Load-use detection: rt is compared even for I-type consumers.
    always_comb begin
        rt_used  = (ex_rt == id_rs) | (ex_rt == id_rt);
        hazard   = id_valid & ex_valid & ex_ctrl[MEMREAD]
                 & (ex_rt != '0) & rt_used;
        stall_id = (hazard | hold) & ~flush;
        cnt_full = (bubble_cnt == {CNT_W{1'b1}});
    end

    // Control bundle and valid: flush/bubble zero them, hold freezes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end else if (flush || (!hold && hazard)) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end else if (!hold) begin
            ex_valid <= id_valid;
            ex_ctrl  <= id_valid ? id_ctrl : 15'd0;
        end
    end

    // Operand data and specifiers load on every edge except hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_pc4     <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
        end else if (flush || !hold) begin
            ex_pc4     <= id_pc4;
            ex_rs_data <= id_rs_data;
            ex_rt_data <= id_rt_data;
            ex_imm     <= id_imm;
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_rd      <= id_rd;
        end
    end

    // Saturating count of bubbles actually inserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (!flush && !hold && hazard && !cnt_full) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed table-driven bench for id_ex_pipe_reg.
// A second instance with a 2-bit counter covers saturation.
module tb_id_ex_pipe_reg;

    localparam logic [14:0] LW  = 15'h3500;
    localparam logic [14:0] ADD = 15'h1808;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [14:0] id_ctrl;
    logic [31:0] id_pc4, id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        flush, hold;
    logic        ex_valid, s_valid;
    logic [14:0] ex_ctrl, s_ctrl;
    logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
    logic [31:0] s_pc4, s_rs_data, s_rt_data, s_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd, s_rs, s_rt, s_rd;
    logic        stall_id, s_stall;
    logic [15:0] bubble_cnt;
    logic [1:0]  s_cnt;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .flush(flush), .hold(hold), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
        .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .stall_id(stall_id), .bubble_cnt(bubble_cnt)
    );

    id_ex_pipe_reg #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .flush(flush), .hold(hold), .ex_valid(s_valid), .ex_ctrl(s_ctrl),
        .ex_pc4(s_pc4), .ex_rs_data(s_rs_data), .ex_rt_data(s_rt_data),
        .ex_imm(s_imm), .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd),
        .stall_id(s_stall), .bubble_cnt(s_cnt)
    );

    typedef struct {
        logic        v;
        logic [14:0] ctrl;
        logic [4:0]  rs, rt;
        logic [31:0] imm;
        logic        fl, ho;
        logic        e_stall, e_valid;
        logic [14:0] e_ctrl;
        logic [4:0]  e_rs, e_rt;
        logic [31:0] e_imm;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(
        input logic v, input logic [14:0] ctrl,
        input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] imm,
        input logic fl, input logic ho, input logic e_stall,
        input logic e_valid, input logic [14:0] e_ctrl,
        input logic [4:0] e_rs, input logic [4:0] e_rt,
        input logic [31:0] e_imm, input logic [15:0] e_cnt);
        vec_t t;
        t.v = v; t.ctrl = ctrl; t.rs = rs; t.rt = rt; t.imm = imm;
        t.fl = fl; t.ho = ho; t.e_stall = e_stall; t.e_valid = e_valid;
        t.e_ctrl = e_ctrl; t.e_rs = e_rs; t.e_rt = e_rt;
        t.e_imm = e_imm; t.e_cnt = e_cnt;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic drive(input logic v, input logic [14:0] ctrl,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic [31:0] imm, input logic fl,
                         input logic ho);
        id_valid   = v;
        id_ctrl    = ctrl;
        id_rs      = rs;
        id_rt      = rt;
        id_rd      = rt ^ 5'h10;
        id_imm     = imm;
        id_pc4     = imm + 32'd4;
        id_rs_data = ~imm;
        id_rt_data = imm ^ 32'h5A5A_5A5A;
        flush      = fl;
        hold       = ho;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string name);
        logic [255:0] all;
        all = {ex_valid, ex_ctrl, ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
               ex_rs, ex_rt, ex_rd, stall_id, bubble_cnt};
        check(name, 64'(all != '0), 64'd0);
    endtask

    initial begin
        drive(1'b0, 15'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0);
        rst = 1'b1;
        #3;
        check_zero("reset_state");
        #4;
        rst = 1'b0;

        // lw / load-use / $zero / flush / id_valid=0 / hold / hazard+flush
        tv.push_back(mk(1, LW,  29, 8, 32'h04, 0, 0, 0, 1, LW,  29, 8, 32'h04, 0));
        tv.push_back(mk(1, ADD,  8, 9, 32'h10, 0, 0, 1, 0, 0,    8, 9, 32'h10, 1));
        tv.push_back(mk(1, ADD,  8, 9, 32'h10, 0, 0, 0, 1, ADD,  8, 9, 32'h10, 1));
        tv.push_back(mk(1, LW,   0, 0, 32'h08, 0, 0, 0, 1, LW,   0, 0, 32'h08, 1));
        tv.push_back(mk(1, ADD,  0, 0, 32'h14, 0, 0, 0, 1, ADD,  0, 0, 32'h14, 1));
        tv.push_back(mk(1, LW,   1, 8, 32'h0C, 0, 0, 0, 1, LW,   1, 8, 32'h0C, 1));
        tv.push_back(mk(1, ADD,  2, 8, 32'h18, 1, 0, 0, 0, 0,    2, 8, 32'h18, 1));
        tv.push_back(mk(0, ADD,  8, 3, 32'h1C, 0, 0, 0, 0, 0,    8, 3, 32'h1C, 1));
        tv.push_back(mk(1, LW,   4, 8, 32'h20, 0, 0, 0, 1, LW,   4, 8, 32'h20, 1));
        tv.push_back(mk(0, ADD,  8, 5, 32'h24, 0, 0, 0, 0, 0,    8, 5, 32'h24, 1));
        tv.push_back(mk(1, LW,   6, 8, 32'h28, 0, 0, 0, 1, LW,   6, 8, 32'h28, 1));
        tv.push_back(mk(1, ADD,  7, 8, 32'h2C, 0, 1, 1, 1, LW,   6, 8, 32'h28, 1));
        tv.push_back(mk(1, ADD,  7, 8, 32'h2C, 0, 1, 1, 1, LW,   6, 8, 32'h28, 1));
        tv.push_back(mk(1, ADD,  7, 8, 32'h2C, 0, 1, 1, 1, LW,   6, 8, 32'h28, 1));
        tv.push_back(mk(1, ADD,  7, 8, 32'h2C, 0, 0, 1, 0, 0,    7, 8, 32'h2C, 2));
        tv.push_back(mk(1, ADD,  7, 8, 32'h2C, 0, 0, 0, 1, ADD,  7, 8, 32'h2C, 2));
        tv.push_back(mk(1, LW,   1, 9, 32'h30, 0, 0, 0, 1, LW,   1, 9, 32'h30, 2));
        tv.push_back(mk(1, ADD,  9, 2, 32'h34, 1, 0, 0, 0, 0,    9, 2, 32'h34, 2));

        foreach (tv[i]) begin
            drive(tv[i].v, tv[i].ctrl, tv[i].rs, tv[i].rt, tv[i].imm,
                  tv[i].fl, tv[i].ho);
            #1;
            check($sformatf("v%0d stall_id", i), 64'(stall_id),
                  64'(tv[i].e_stall));
            cycle();
            check($sformatf("v%0d ex_valid", i), 64'(ex_valid),
                  64'(tv[i].e_valid));
            check($sformatf("v%0d ex_ctrl", i), 64'(ex_ctrl),
                  64'(tv[i].e_ctrl));
            check($sformatf("v%0d ex_rs/rt/rd", i),
                  64'({ex_rs, ex_rt, ex_rd}),
                  64'({tv[i].e_rs, tv[i].e_rt, tv[i].e_rt ^ 5'h10}));
            check($sformatf("v%0d ex_imm/pc4", i), {ex_imm, ex_pc4},
                  {tv[i].e_imm, tv[i].e_imm + 32'd4});
            check($sformatf("v%0d ex_data", i), {ex_rs_data, ex_rt_data},
                  {~tv[i].e_imm, tv[i].e_imm ^ 32'h5A5A_5A5A});
            check($sformatf("v%0d bubble_cnt", i), 64'(bubble_cnt),
                  64'(tv[i].e_cnt));
        end

        // Asynchronous reset in the middle of a cycle with ctrl all ones.
        drive(1'b1, 15'h7FFF, 5'd3, 5'd4, 32'h40, 1'b0, 1'b0);
        cycle();
        check("pre_rst ex_ctrl", 64'(ex_ctrl), 64'h7FFF);
        drive(1'b1, ADD, 5'd4, 5'd1, 32'h44, 1'b0, 1'b0);
        #1;
        check("pre_rst stall_id", 64'(stall_id), 64'd1);
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        #1;
        rst = 1'b0;
        drive(1'b0, 15'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0);
        cycle();

        // Five load-use pairs: wide counter reaches 5, 2-bit one sticks at 3.
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, LW, 5'd1, 5'd8, 32'h50, 1'b0, 1'b0);
            cycle();
            drive(1'b1, ADD, 5'd8, 5'd2, 32'h54, 1'b0, 1'b0);
            #1;
            check($sformatf("sat%0d stall_id", k), 64'(stall_id), 64'd1);
            cycle();
            cycle();
        end
        check("sat cnt16", 64'(bubble_cnt), 64'd5);
        check("sat cnt2", 64'(s_cnt), 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
